// File: rtl/bus_master.sv
// bus_master: sequences one CPU load/store at a time onto the system bus with per-region hold time.
// Optional request legality checking and the err port are enabled by defining BUS_MASTER_CHECK_EN.
module bus_master #(
    parameter int DRAM_CYCLES = 2,
    parameter int IO_CYCLES   = 1
) (
    input  logic        sck,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
`ifdef BUS_MASTER_CHECK_EN
    output logic        err,
`endif
    output logic        stall,
    output logic        bus_en,
    output logic        bus_rw,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  dbg_state
);

    // Handshake: req is a level sampled only in IDLE; ack is a one-cycle pulse and
    // stall stays high from the accepting cycle until (not including) the ack cycle.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] DRAM_INIT = 4'(DRAM_CYCLES - 1);
    localparam logic [3:0] IO_INIT   = 4'(IO_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_ack;
    logic        r_bus_en;
    logic        r_bus_rw;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;

    logic        w_dram;
    logic [3:0]  w_cnt_init;
    logic        w_illegal;

    assign w_dram     = (addr[31:20] == 12'h001);
    assign w_cnt_init = w_dram ? DRAM_INIT : IO_INIT;

`ifdef BUS_MASTER_CHECK_EN
    logic r_err;
    logic w_be_ok;
    logic w_half;
    logic w_mis_word;
    logic w_mis_half;
    logic w_mapped;

    always_comb begin
        w_be_ok = 1'b0;
        case (be)
            4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: w_be_ok = 1'b1;
            default:                            w_be_ok = 1'b0;
        endcase
    end

    assign w_half     = (be == 4'b0011) || (be == 4'b1100);
    assign w_mis_word = (be == 4'b1111) && (addr[1:0] != 2'b00);
    assign w_mis_half = w_half && addr[0];
    assign w_mapped   = (addr[31:20] == 12'h000) || (addr[31:20] == 12'h001) ||
                        (addr[31:20] == 12'h010);
    assign w_illegal  = !w_be_ok || w_mis_word || w_mis_half || !w_mapped;
    assign err        = r_err;
`else
    assign w_illegal  = 1'b0;
`endif

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_rdata     <= 32'h0;
            r_ack       <= 1'b0;
            r_bus_en    <= 1'b0;
            r_bus_rw    <= 1'b0;
            r_bus_sel   <= 4'd0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
`ifdef BUS_MASTER_CHECK_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
`ifdef BUS_MASTER_CHECK_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        if (w_illegal) begin
                            // Rejected requests never reach the bus.
                            r_state <= S_DONE;
                            r_ack   <= 1'b1;
`ifdef BUS_MASTER_CHECK_EN
                            r_err   <= 1'b1;
`endif
                        end else begin
                            r_state     <= S_ACCESS;
                            r_cnt       <= w_cnt_init;
                            r_bus_en    <= 1'b1;
                            r_bus_rw    <= we;
                            r_bus_sel   <= be;
                            r_bus_addr  <= addr;
                            r_bus_wdata <= wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_bus_rw) begin
                            r_rdata <= bus_rdata;
                        end
                        r_ack       <= 1'b1;
                        r_state     <= S_DONE;
                        r_bus_en    <= 1'b0;
                        r_bus_rw    <= 1'b0;
                        r_bus_sel   <= 4'd0;
                        r_bus_addr  <= 32'h0;
                        r_bus_wdata <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall     = ((r_state == S_IDLE) && req) || (r_state == S_ACCESS);
    assign rdata     = r_rdata;
    assign ack       = r_ack;
    assign bus_en    = r_bus_en;
    assign bus_rw    = r_bus_rw;
    assign bus_sel   = r_bus_sel;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: vector table of single transactions plus hand-written
// sequences for idle-after-reset, back-to-back, reset mid-access and (optionally) rejected requests.
module tb_bus_master;

    logic        sck;
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
`ifdef BUS_MASTER_CHECK_EN
    logic        err;
`endif
    logic        stall;
    logic        bus_en;
    logic        bus_rw;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [1:0]  dbg_state;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;

    int total;
    int bad;

    bus_master #(.DRAM_CYCLES(2), .IO_CYCLES(1)) dut (
        .sck       (sck),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .be        (be),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ack       (ack),
`ifdef BUS_MASTER_CHECK_EN
        .err       (err),
`endif
        .stall     (stall),
        .bus_en    (bus_en),
        .bus_rw    (bus_rw),
        .bus_sel   (bus_sel),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        sck = 1'b0;
        forever #5 sck = ~sck;
    end

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brd;
        int          n_cyc;
        int          lat;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sck);
        #1;
    endtask

    task automatic run_vec(input int i);
        int en_cnt;
        int ack_cyc;
        we        = vecs[i].we;
        be        = vecs[i].be;
        addr      = vecs[i].addr;
        wdata     = vecs[i].wdata;
        bus_rdata = vecs[i].brd;
        req       = 1'b1;
        #1;
        check("stall_c0", stall, 1'b1);
        en_cnt  = 0;
        ack_cyc = -1;
        for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
            tick();
            if (bus_en) begin
                en_cnt++;
                check("bus_addr", bus_addr, vecs[i].addr);
                check("bus_sel", bus_sel, vecs[i].be);
                check("bus_wdata", bus_wdata, vecs[i].wdata);
                check("bus_rw", bus_rw, vecs[i].we);
            end
            if (ack) begin
                ack_cyc = c;
                check("rdata_at_ack", rdata, vecs[i].exp_rdata);
                check("stall_at_ack", stall, 1'b0);
                check("bus_en_at_ack", bus_en, 1'b0);
`ifdef BUS_MASTER_CHECK_EN
                check("err_legal", err, 1'b0);
`endif
                req = 1'b0;
            end else begin
                check("stall_busy", stall, 1'b1);
            end
        end
        check("ack_latency", ack_cyc, vecs[i].lat);
        check("bus_en_cycles", en_cnt, vecs[i].n_cyc);
        tick();
        check("ack_one_cycle", ack, 1'b0);
        check("idle_after", dbg_state, ST_IDLE);
        check("rdata_held", rdata, vecs[i].exp_rdata);
    endtask

    // stimulus + scoreboard
    initial begin
        int ack_times[$];
        int en_cnt;
        logic saw_ack;
        total = 0;
        bad   = 0;

        vecs[0] = '{1'b0, 4'b1111, 32'h0010_0040, 32'h0000_0000, 32'hDEAD_BEEF, 2, 3, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 4'b0001, 32'h0100_0000, 32'h0000_00A5, 32'h1234_5678, 1, 2, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 4'b0011, 32'h0100_0010, 32'h0F0F_0F0F, 32'hCAFE_0001, 1, 2, 32'hCAFE_0001};
        vecs[3] = '{1'b1, 4'b1100, 32'h0010_0100, 32'h55AA_0000, 32'h9999_9999, 2, 3, 32'hCAFE_0001};
        vecs[4] = '{1'b0, 4'b1111, 32'h0000_0008, 32'h0000_0000, 32'h0000_0000, 1, 2, 32'h0000_0000};
        vecs[5] = '{1'b0, 4'b1000, 32'h0010_0003, 32'h7777_0000, 32'h1122_3344, 2, 3, 32'h1122_3344};

        rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'd0; addr = 32'h0; wdata = 32'h0;
        bus_rdata = 32'h0;
        repeat (2) @(posedge sck);
        #2;
        rst = 1'b0;

        for (int c = 0; c < 10; c++) begin
            tick();
            check("rst_bus_en", bus_en, 1'b0);
            check("rst_ack", ack, 1'b0);
            check("rst_rdata", rdata, 32'h0);
            check("rst_stall", stall, 1'b0);
            check("rst_bus_addr", bus_addr, 32'h0);
            check("rst_state", dbg_state, ST_IDLE);
        end

        for (int i = 0; i < 6; i++) begin
            run_vec(i);
        end

        // back-to-back DRAM loads with req held high
        we = 1'b0; be = 4'b1111; addr = 32'h0010_0080; wdata = 32'h0;
        bus_rdata = 32'hA1A1_0001;
        req = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (ack) begin
                ack_times.push_back(c);
                if (ack_times.size() == 1) begin
                    check("b2b_rdata1", rdata, 32'hA1A1_0001);
                    bus_rdata = 32'hB2B2_0002;
                end else begin
                    check("b2b_rdata2", rdata, 32'hB2B2_0002);
                    req = 1'b0;
                end
            end
            if (c == 4) begin
                check("b2b_idle_gap", dbg_state, ST_IDLE);
                check("b2b_stall_gap", stall, 1'b1);
            end
            if (c == 5) check("b2b_second_accept", dbg_state, ST_ACCESS);
        end
        check("b2b_ack_count", ack_times.size(), 2);
        if (ack_times.size() == 2) begin
            check("b2b_ack1_cycle", ack_times[0], 3);
            check("b2b_ack_spacing", ack_times[1] - ack_times[0], 4);
        end

`ifdef BUS_MASTER_CHECK_EN
        // misaligned word: rejected straight to DONE
        we = 1'b0; be = 4'b1111; addr = 32'h0010_0042; bus_rdata = 32'h5555_5555;
        req = 1'b1;
        #1;
        check("chk_stall_c0", stall, 1'b1);
        tick();
        check("chk_ack", ack, 1'b1);
        check("chk_err", err, 1'b1);
        check("chk_bus_en", bus_en, 1'b0);
        check("chk_rdata", rdata, 32'hB2B2_0002);
        req = 1'b0;
        tick();
        check("chk_err_pulse", err, 1'b0);
        check("chk_idle", dbg_state, ST_IDLE);
        // unmapped region and illegal byte enable
        addr = 32'h0300_0000; be = 4'b0001; req = 1'b1;
        tick();
        check("chk_unmapped_err", err, 1'b1);
        check("chk_unmapped_en", bus_en, 1'b0);
        req = 1'b0;
        tick();
        addr = 32'h0100_0000; be = 4'b0101; req = 1'b1;
        tick();
        check("chk_be_err", err, 1'b1);
        req = 1'b0;
        tick();
`endif

        // reset pulse during the first DRAM access cycle
        we = 1'b1; be = 4'b1111; addr = 32'h0010_0200; wdata = 32'h1357_9BDF;
        req = 1'b1;
        tick();
        check("rstmid_bus_en_before", bus_en, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_bus_en_drop", bus_en, 1'b0);
        check("rstmid_state", dbg_state, ST_IDLE);
        req = 1'b0;
        @(negedge sck);
        rst = 1'b0;
        saw_ack = 1'b0;
        en_cnt  = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ack) saw_ack = 1'b1;
            if (bus_en) en_cnt++;
        end
        check("rstmid_no_ack", saw_ack, 1'b0);
        check("rstmid_no_bus_en", en_cnt, 0);
        check("rstmid_idle", dbg_state, ST_IDLE);
        check("rstmid_rdata", rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
